// File: rtl/alu_arbiter_pkg.sv
// Shared types and build-wide widths/opcodes for the two-port ALU arbiter.
// The DEF_HEADDER block mirrors def.h so that the widths are defined exactly once.
`ifndef DEF_HEADDER
`define DEF_HEADDER
`define ALU_SEL_W 6
`define DATA_W    64
`define ALU_AND   6'd0
`define ALU_OR    6'd1
`define ALU_ADD   6'd2
`define ALU_XOR   6'd4
`define ALU_SUB   6'd6
`endif

package alu_arb_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef logic req_idx_t;

   // last_grant resets to port 1 so that port 0 wins the first contention
   localparam req_idx_t LAST_GRANT_RST = 1'b1;
endpackage

// File: rtl/alu_arbiter_if.sv
// One requester channel: request handshake with ALU operands, response handshake with result.
interface alu_arbiter_if;
   logic                  req_valid;
   logic                  req_ready;
   logic [`ALU_SEL_W-1:0] req_ctl;
   logic [`DATA_W-1:0]    req_a;
   logic [`DATA_W-1:0]    req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [`DATA_W-1:0]    rsp_result;
   logic                  rsp_zero;

   modport master (
      output req_valid, req_ctl, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_zero
   );

   modport slave (
      input  req_valid, req_ctl, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_zero
   );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way grant selection; round-robin by default, fixed priority (port 0) with ALU_ARB_FIXED_PRI_EN.
module rr_arb2
   import alu_arb_pkg::*;
(
   input  logic [1:0] i_valid,
   input  req_idx_t   i_last_grant,
   output req_idx_t   o_grant
);
`ifdef ALU_ARB_FIXED_PRI_EN
   assign o_grant = i_valid[0] ? 1'b0 : i_valid[1];
`else
   always_comb begin
      o_grant = 1'b0;
      if (i_valid == 2'b11) begin
         o_grant = ~i_last_grant;
      end else begin
         o_grant = i_valid[1];
      end
   end
`endif
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters: IDLE -> EXEC -> RESP.
// Arbitration is round-robin unless ALU_ARB_FIXED_PRI_EN selects fixed port-0 priority.
module alu_arbiter
   import alu_arb_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   alu_arbiter_if.slave          i_req0,
   alu_arbiter_if.slave          i_req1,
   output logic [`ALU_SEL_W-1:0] o_alu_ctl,
   output logic [`DATA_W-1:0]    o_alu_a,
   output logic [`DATA_W-1:0]    o_alu_b,
   input  logic [`DATA_W-1:0]    i_alu_out,
   input  logic                  i_alu_zero
);
   localparam logic [1:0] S_IDLE = 2'(IDLE);
   localparam logic [1:0] S_EXEC = 2'(EXEC);
   localparam logic [1:0] S_RESP = 2'(RESP);

   logic [1:0]            r_state;
   req_idx_t              r_gnt;
   logic [`ALU_SEL_W-1:0] r_ctl;
   logic [`DATA_W-1:0]    r_a;
   logic [`DATA_W-1:0]    r_b;
   logic [`DATA_W-1:0]    r_result;
   logic                  r_zero;

   logic [1:0]            w_valid;
   req_idx_t              w_grant;
   req_idx_t              w_last_grant;
   logic                  w_accept;

   assign w_valid  = {i_req1.req_valid, i_req0.req_valid};
   assign w_accept = (r_state == S_IDLE) && !rst && (w_valid != 2'b00);

`ifdef ALU_ARB_FIXED_PRI_EN
   assign w_last_grant = LAST_GRANT_RST;
`else
   req_idx_t r_last_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= LAST_GRANT_RST;
      end else if (w_accept) begin
         r_last_grant <= w_grant;
      end
   end

   assign w_last_grant = r_last_grant;
`endif

   rr_arb2 u_rr_arb2 (
      .i_valid      (w_valid),
      .i_last_grant (w_last_grant),
      .o_grant      (w_grant)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_gnt    <= 1'b0;
         r_ctl    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_zero   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_gnt   <= w_grant;
                  r_ctl   <= w_grant ? i_req1.req_ctl : i_req0.req_ctl;
                  r_a     <= w_grant ? i_req1.req_a   : i_req0.req_a;
                  r_b     <= w_grant ? i_req1.req_b   : i_req0.req_b;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_result <= i_alu_out;
               r_zero   <= i_alu_zero;
               r_state  <= S_RESP;
            end
            S_RESP: begin
               if (r_gnt ? i_req1.rsp_ready : i_req0.rsp_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign i_req0.req_ready  = w_accept && (w_grant == 1'b0) && i_req0.req_valid;
   assign i_req1.req_ready  = w_accept && (w_grant == 1'b1) && i_req1.req_valid;

   assign i_req0.rsp_valid  = (r_state == S_RESP) && (r_gnt == 1'b0);
   assign i_req1.rsp_valid  = (r_state == S_RESP) && (r_gnt == 1'b1);
   assign i_req0.rsp_result = r_result;
   assign i_req1.rsp_result = r_result;
   assign i_req0.rsp_zero   = r_zero;
   assign i_req1.rsp_zero   = r_zero;

   // The ALU only sees operands during the single EXEC cycle
   assign o_alu_ctl = (r_state == S_EXEC) ? r_ctl : '0;
   assign o_alu_a   = (r_state == S_EXEC) ? r_a   : '0;
   assign o_alu_b   = (r_state == S_EXEC) ? r_b   : '0;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to its ALU port.
module tb_alu_arbiter;
   logic                  clk = 1'b0;
   logic                  rst;
   logic [`ALU_SEL_W-1:0] alu_ctl;
   logic [`DATA_W-1:0]    alu_a;
   logic [`DATA_W-1:0]    alu_b;
   logic [`DATA_W-1:0]    alu_out;
   logic                  alu_zero;
   int                    n_total = 0;
   int                    n_pass  = 0;

   always #5 clk = ~clk;

   alu_arbiter_if u_p0 ();
   alu_arbiter_if u_p1 ();

   alu_arbiter u_dut (
      .clk       (clk),
      .rst       (rst),
      .i_req0    (u_p0),
      .i_req1    (u_p1),
      .o_alu_ctl (alu_ctl),
      .o_alu_a   (alu_a),
      .o_alu_b   (alu_b),
      .i_alu_out (alu_out),
      .i_alu_zero(alu_zero)
   );

   always_comb begin
      alu_out = '0;
      case (alu_ctl)
         `ALU_AND: alu_out = alu_a & alu_b;
         `ALU_OR:  alu_out = alu_a | alu_b;
         `ALU_ADD: alu_out = alu_a + alu_b;
         `ALU_XOR: alu_out = alu_a ^ alu_b;
         `ALU_SUB: alu_out = alu_a - alu_b;
         default:  alu_out = '0;
      endcase
      alu_zero = (alu_out == '0);
   end

   typedef struct {
      int                    port;
      logic [`ALU_SEL_W-1:0] ctl;
      logic [`DATA_W-1:0]    a;
      logic [`DATA_W-1:0]    b;
      logic [`DATA_W-1:0]    res;
      logic                  zero;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic set_req(input int p, input logic v, input logic [`ALU_SEL_W-1:0] c,
                          input logic [`DATA_W-1:0] a, input logic [`DATA_W-1:0] b);
      if (p == 0) begin
         u_p0.req_valid = v; u_p0.req_ctl = c; u_p0.req_a = a; u_p0.req_b = b;
      end else begin
         u_p1.req_valid = v; u_p1.req_ctl = c; u_p1.req_a = a; u_p1.req_b = b;
      end
   endtask

   function automatic logic rdy(input int p);
      return (p == 0) ? u_p0.req_ready : u_p1.req_ready;
   endfunction

   function automatic logic rvld(input int p);
      return (p == 0) ? u_p0.rsp_valid : u_p1.rsp_valid;
   endfunction

   task automatic apply_reset();
      rst = 1'b1;
      set_req(0, 1'b1, `ALU_ADD, 64'd1, 64'd1);
      @(posedge clk); #2;
      chk("rst_req0_ready", {63'd0, u_p0.req_ready}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      set_req(0, 1'b0, '0, '0, '0);
      #1;
      chk("rst_rsp_valid", {62'd0, u_p1.rsp_valid, u_p0.rsp_valid}, 64'd0);
      chk("rst_alu_idle", alu_a | alu_b | {58'd0, alu_ctl}, 64'd0);
   endtask

   task automatic wait_ready(input int p);
      int n = 0;
      while (!rdy(p) && n < 20) begin
         @(posedge clk); #2;
         n++;
      end
      chk("req_ready_seen", {63'd0, rdy(p)}, 64'd1);
   endtask

   task automatic do_op(input vec_t v);
      int o = 1 - v.port;
      set_req(v.port, 1'b1, v.ctl, v.a, v.b);
      #1;
      wait_ready(v.port);
      @(posedge clk); #1;
      set_req(v.port, 1'b0, '0, '0, '0);
      #1;
      chk("exec_alu_ctl", {58'd0, alu_ctl}, {58'd0, v.ctl});
      chk("exec_alu_a", alu_a, v.a);
      chk("exec_alu_b", alu_b, v.b);
      chk("exec_rsp_valid", {63'd0, rvld(v.port)}, 64'd0);
      @(posedge clk); #2;
      chk("resp_valid", {63'd0, rvld(v.port)}, 64'd1);
      chk("resp_other_valid", {63'd0, rvld(o)}, 64'd0);
      chk("resp_result", (v.port == 0) ? u_p0.rsp_result : u_p1.rsp_result, v.res);
      chk("resp_zero", {63'd0, (v.port == 0) ? u_p0.rsp_zero : u_p1.rsp_zero}, {63'd0, v.zero});
      chk("resp_alu_idle", alu_a | alu_b | {58'd0, alu_ctl}, 64'd0);
      if (v.port == 0) u_p0.rsp_ready = 1'b1; else u_p1.rsp_ready = 1'b1;
      @(posedge clk); #1;
      u_p0.rsp_ready = 1'b0;
      u_p1.rsp_ready = 1'b0;
      #1;
      chk("idle_rsp_valid", {63'd0, rvld(v.port)}, 64'd0);
   endtask

   initial begin
      vec_t vecs[6];
      vec_t v;
      int   exp_g;
      int   n;
      logic g;

      vecs[0] = '{0, `ALU_ADD, 64'd5,      64'd3,      64'd8,      1'b0};
      vecs[1] = '{1, `ALU_SUB, 64'd7,      64'd7,      64'd0,      1'b1};
      vecs[2] = '{0, `ALU_XOR, 64'hF0,     64'hFF,     64'h0F,     1'b0};
      vecs[3] = '{1, `ALU_AND, 64'hFF00,   64'h0FF0,   64'h0F00,   1'b0};
      vecs[4] = '{0, `ALU_SUB, 64'd3,      64'd5,      64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
      vecs[5] = '{1, `ALU_OR,  64'd0,      64'd0,      64'd0,      1'b1};

      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      u_p0.rsp_ready = 1'b0;
      u_p1.rsp_ready = 1'b0;
      #1;
      apply_reset();

      for (int i = 0; i < 6; i++) do_op(vecs[i]);

      // Contention from reset: round-robin alternates starting at port 0
      apply_reset();
      set_req(0, 1'b1, `ALU_ADD, 64'd1, 64'd1);
      set_req(1, 1'b1, `ALU_SUB, 64'd9, 64'd4);
      u_p0.rsp_ready = 1'b1;
      u_p1.rsp_ready = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (!(u_p0.req_ready || u_p1.req_ready) && n < 20) begin
            @(posedge clk); #2;
            n++;
         end
`ifdef ALU_ARB_FIXED_PRI_EN
         exp_g = 0;
`else
         exp_g = k % 2;
`endif
         chk("cont_one_ready", {63'd0, u_p0.req_ready & u_p1.req_ready}, 64'd0);
         g = u_p1.req_ready;
         chk("cont_grant", {63'd0, g}, exp_g);
         @(posedge clk); #2;
      end
      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      u_p0.rsp_ready = 1'b0;
      u_p1.rsp_ready = 1'b0;

      // Backpressure on port 0 with both ports queued behind it
      apply_reset();
      set_req(0, 1'b1, `ALU_ADD, 64'd10, 64'd20);
      #1;
      wait_ready(0);
      @(posedge clk); #1;
      set_req(0, 1'b1, `ALU_ADD, 64'd2, 64'd2);
      set_req(1, 1'b1, `ALU_XOR, 64'd1, 64'd3);
      @(posedge clk); #2;
      for (int k = 0; k < 5; k++) begin
         chk("bp_rsp0_valid", {63'd0, u_p0.rsp_valid}, 64'd1);
         chk("bp_rsp0_result", u_p0.rsp_result, 64'd30);
         chk("bp_req_ready", {62'd0, u_p1.req_ready, u_p0.req_ready}, 64'd0);
         @(posedge clk); #2;
      end
      u_p0.rsp_ready = 1'b1;
      @(posedge clk); #1;
      u_p0.rsp_ready = 1'b0;
      #1;
`ifdef ALU_ARB_FIXED_PRI_EN
      exp_g = 0;
`else
      exp_g = 1;
`endif
      chk("bp_release_valid", {63'd0, u_p0.rsp_valid}, 64'd0);
      chk("bp_next_grant1", {63'd0, u_p1.req_ready}, (exp_g == 1) ? 64'd1 : 64'd0);
      chk("bp_next_grant0", {63'd0, u_p0.req_ready}, (exp_g == 0) ? 64'd1 : 64'd0);
      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      @(posedge clk); #1;

      // Reset while in EXEC after a port-0 grant: port 0 must still win next
      set_req(0, 1'b1, `ALU_SUB, 64'd50, 64'd8);
      #1;
      wait_ready(0);
      @(posedge clk); #1;
      rst = 1'b1;
      set_req(0, 1'b1, `ALU_ADD, 64'd5, 64'd3);
      set_req(1, 1'b1, `ALU_SUB, 64'd7, 64'd7);
      #1;
      chk("midrst_req_ready", {62'd0, u_p1.req_ready, u_p0.req_ready}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midrst_rsp_valid", {62'd0, u_p1.rsp_valid, u_p0.rsp_valid}, 64'd0);
      chk("midrst_alu_idle", alu_a | alu_b | {58'd0, alu_ctl}, 64'd0);
      chk("midrst_grant", {62'd0, u_p1.req_ready, u_p0.req_ready}, 64'd1);
      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      @(posedge clk); #1;
      v = '{0, `ALU_ADD, 64'd5, 64'd3, 64'd8, 1'b0};
      do_op(v);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
